// File: rtl/clock_ui_pkg.sv
// Shared encodings for the clock/calendar key UI: FSM states, screen codes and field positions.
package clock_ui_pkg;

    typedef enum logic [0:0] {
        ST_NORMAL = 1'b0,
        ST_EDIT   = 1'b1
    } state_e;

    typedef logic [1:0] screen_t;
    typedef logic [2:0] pos_t;

    localparam screen_t SCR_TIME = 2'd0;
    localparam screen_t SCR_DATE = 2'd1;
    localparam screen_t SCR_TZ   = 2'd2;

    localparam pos_t POS_F0 = 3'd0;
    localparam pos_t POS_F1 = 3'd2;
    localparam pos_t POS_F2 = 3'd4;

endpackage

// File: rtl/edit_key_sequencer_if.sv
// Raw keys in, display/counter control out; master drives keys, slave is the sequencer.
interface edit_key_sequencer_if;
    import clock_ui_pkg::*;

    logic    key_edit;
    logic    key_plus;
    logic    key_minus;
    logic    key_swi;
    screen_t screen;
    logic    edit_mode;
    pos_t    edit_pos;
    logic    inc_pulse;
    logic    dec_pulse;
    logic    flick;

    modport master (
        output key_edit, key_plus, key_minus, key_swi,
        input  screen, edit_mode, edit_pos, inc_pulse, dec_pulse, flick
    );

    modport slave (
        input  key_edit, key_plus, key_minus, key_swi,
        output screen, edit_mode, edit_pos, inc_pulse, dec_pulse, flick
    );

endinterface

// File: rtl/key_debounce.sv
// One active-low raw key: 2-FF synchronizer, stability counter and a one-cycle press strobe.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 500_000
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic key_ni,
    output logic pressed_o,
    output logic press_o
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYC - 1);

    logic            sync1_q, sync2_q;
    logic            level_q;  // raw polarity: 1 = released
    logic [CntW-1:0] cnt_q;
    logic            press_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= key_ni;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CntLast) begin
                level_q <= sync2_q;
                cnt_q   <= '0;
                press_q <= ~sync2_q;
            end else begin
                cnt_q <= cnt_q + CntW'(1);
            end
        end
    end

    assign pressed_o = ~level_q;
    assign press_o   = press_q;

endmodule

// File: rtl/edit_key_sequencer.sv
// Key UI sequencer: screen select, field edit with hold-to-repeat, idle timeout and blink phase.
module edit_key_sequencer
    import clock_ui_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC     = 500_000,
    parameter int unsigned REPEAT_DELAY_CYC = 25_000_000,
    parameter int unsigned REPEAT_RATE_CYC  = 5_000_000,
    parameter int unsigned TIMEOUT_CYC      = 500_000_000,
    parameter int unsigned FLICK_CYC        = 12_500_000
) (
    input logic                  clk,
    input logic                  reset,
    edit_key_sequencer_if.slave  bus
);

    localparam int unsigned RepMax = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ?
                                     REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
    localparam int unsigned RepW = $clog2(RepMax + 1);
    localparam int unsigned ToW  = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned FlW  = $clog2(FLICK_CYC + 1);

    localparam logic [RepW-1:0] RepDelayLast = RepW'(REPEAT_DELAY_CYC - 1);
    localparam logic [RepW-1:0] RepRateLast  = RepW'(REPEAT_RATE_CYC - 1);
    localparam logic [ToW-1:0]  ToLast       = ToW'(TIMEOUT_CYC - 1);
    localparam logic [ToW-1:0]  ToMax        = ToW'(TIMEOUT_CYC);
    localparam logic [FlW-1:0]  FlLast       = FlW'(FLICK_CYC - 1);

    logic e_press, p_press, m_press, s_press;
    logic p_lvl, m_lvl, e_lvl, s_lvl;
    logic unused_lvl;

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_edit (
        .clk_i(clk), .reset_i(reset), .key_ni(bus.key_edit), .pressed_o(e_lvl), .press_o(e_press)
    );
    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_plus (
        .clk_i(clk), .reset_i(reset), .key_ni(bus.key_plus), .pressed_o(p_lvl), .press_o(p_press)
    );
    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_minus (
        .clk_i(clk), .reset_i(reset), .key_ni(bus.key_minus), .pressed_o(m_lvl), .press_o(m_press)
    );
    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_swi (
        .clk_i(clk), .reset_i(reset), .key_ni(bus.key_swi), .pressed_o(s_lvl), .press_o(s_press)
    );

    assign unused_lvl = e_lvl ^ s_lvl;

    state_e          state_q;
    screen_t         screen_q;
    pos_t            pos_q;
    logic            inc_q, dec_q, flick_q;
    logic [ToW-1:0]  to_cnt_q;
    logic [FlW-1:0]  fl_cnt_q;
    logic [RepW-1:0] p_cnt_q, m_cnt_q;
    logic            p_armed_q, m_armed_q;

    logic            in_edit, p_fire, m_fire, step_up, step_dn, any_event, leave;
    logic [RepW-1:0] p_lim, m_lim;

    assign in_edit = (state_q == ST_EDIT);
    assign p_lim   = p_armed_q ? RepRateLast : RepDelayLast;
    assign m_lim   = m_armed_q ? RepRateLast : RepDelayLast;
    assign p_fire  = in_edit & p_lvl & ~m_lvl & ~p_press & (p_cnt_q == p_lim);
    assign m_fire  = in_edit & m_lvl & ~p_lvl & ~m_press & (m_cnt_q == m_lim);
    // A step needs exactly one of plus/minus held, and an edit press in the same cycle wins.
    assign step_up = in_edit & ~(p_lvl & m_lvl) & ~e_press & (p_press | p_fire);
    assign step_dn = in_edit & ~(p_lvl & m_lvl) & ~e_press & (m_press | m_fire);
    assign any_event = e_press | p_press | m_press | s_press | p_fire | m_fire;
    assign leave = in_edit & ((e_press & (pos_q == POS_F2)) | (~any_event & (to_cnt_q == ToLast)));

    always_ff @(posedge clk) begin
        if (reset) begin
            p_cnt_q   <= '0;
            p_armed_q <= 1'b0;
            m_cnt_q   <= '0;
            m_armed_q <= 1'b0;
        end else begin
            if (!in_edit || !p_lvl || m_lvl || p_press) begin
                p_cnt_q   <= '0;
                p_armed_q <= 1'b0;
            end else if (p_fire) begin
                p_cnt_q   <= '0;
                p_armed_q <= 1'b1;
            end else if (p_cnt_q < p_lim) begin
                p_cnt_q <= p_cnt_q + RepW'(1);
            end
            if (!in_edit || !m_lvl || p_lvl || m_press) begin
                m_cnt_q   <= '0;
                m_armed_q <= 1'b0;
            end else if (m_fire) begin
                m_cnt_q   <= '0;
                m_armed_q <= 1'b1;
            end else if (m_cnt_q < m_lim) begin
                m_cnt_q <= m_cnt_q + RepW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_NORMAL;
            screen_q <= SCR_TIME;
            pos_q    <= POS_F0;
            inc_q    <= 1'b0;
            dec_q    <= 1'b0;
            flick_q  <= 1'b0;
            to_cnt_q <= '0;
            fl_cnt_q <= '0;
        end else begin
            inc_q <= step_up;
            dec_q <= step_dn;
            unique case (state_q)
                ST_NORMAL: begin
                    flick_q  <= 1'b0;
                    fl_cnt_q <= '0;
                    to_cnt_q <= '0;
                    if (s_press) begin
                        case (screen_q)
                            SCR_TIME: screen_q <= SCR_DATE;
                            SCR_DATE: screen_q <= SCR_TZ;
                            default:  screen_q <= SCR_TIME;
                        endcase
                    end
                    if (e_press && screen_q != SCR_TZ) begin
                        state_q <= ST_EDIT;
                        pos_q   <= POS_F0;
                    end
                end
                ST_EDIT: begin
                    if (any_event) begin
                        to_cnt_q <= '0;
                    end else if (to_cnt_q != ToMax) begin
                        to_cnt_q <= to_cnt_q + ToW'(1);
                    end
                    // Re-phase the blink after each step so the new value shows immediately.
                    if (step_up || step_dn) begin
                        fl_cnt_q <= '0;
                        flick_q  <= 1'b0;
                    end else if (fl_cnt_q == FlLast) begin
                        fl_cnt_q <= '0;
                        flick_q  <= ~flick_q;
                    end else begin
                        fl_cnt_q <= fl_cnt_q + FlW'(1);
                    end
                    if (leave) begin
                        state_q  <= ST_NORMAL;
                        pos_q    <= POS_F0;
                        flick_q  <= 1'b0;
                        fl_cnt_q <= '0;
                        to_cnt_q <= '0;
                    end else if (e_press) begin
                        pos_q <= (pos_q == POS_F0) ? POS_F1 : POS_F2;
                    end
                end
                default: state_q <= ST_NORMAL;
            endcase
        end
    end

    assign bus.screen    = screen_q;
    assign bus.edit_mode = in_edit;
    assign bus.edit_pos  = pos_q;
    assign bus.inc_pulse = inc_q;
    assign bus.dec_pulse = dec_q;
    assign bus.flick     = flick_q;

endmodule

// File: tb/tb_edit_key_sequencer.sv
// Directed bench for edit_key_sequencer with shortened timing parameters.
module tb_edit_key_sequencer;

    localparam int K_EDIT  = 0;
    localparam int K_PLUS  = 1;
    localparam int K_MINUS = 2;
    localparam int K_SWI   = 3;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;
    int   cyc;
    int   n_inc;
    int   n_dec;
    int   inc_t[$];

    edit_key_sequencer_if bus ();

    edit_key_sequencer #(
        .DEBOUNCE_CYC    (4),
        .REPEAT_DELAY_CYC(20),
        .REPEAT_RATE_CYC (5),
        .TIMEOUT_CYC     (100),
        .FLICK_CYC       (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n cycles, sampling 1 time unit after each rising edge and logging step pulses.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.inc_pulse === 1'b1) begin
                n_inc++;
                inc_t.push_back(cyc);
            end
            if (bus.dec_pulse === 1'b1) n_dec++;
        end
    endtask

    task automatic clear_log();
        n_inc = 0;
        n_dec = 0;
        inc_t.delete();
    endtask

    task automatic set_key(input int k, input logic v);
        case (k)
            K_EDIT:  bus.key_edit = v;
            K_PLUS:  bus.key_plus = v;
            K_MINUS: bus.key_minus = v;
            default: bus.key_swi = v;
        endcase
    endtask

    task automatic tap(input int k);
        set_key(k, 1'b0);
        step(8);
        set_key(k, 1'b1);
        step(8);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(2);
        n_vec++; if (bus.screen !== 2'd0) begin n_err++; $display("FAIL reset_screen: got %0d want 0", bus.screen); end
        n_vec++; if (bus.edit_mode !== 1'b0) begin n_err++; $display("FAIL reset_edit_mode: got %b want 0", bus.edit_mode); end
        n_vec++; if (bus.edit_pos !== 3'd0) begin n_err++; $display("FAIL reset_edit_pos: got %0d want 0", bus.edit_pos); end
        n_vec++; if (bus.inc_pulse !== 1'b0) begin n_err++; $display("FAIL reset_inc: got %b want 0", bus.inc_pulse); end
        n_vec++; if (bus.dec_pulse !== 1'b0) begin n_err++; $display("FAIL reset_dec: got %b want 0", bus.dec_pulse); end
        n_vec++; if (bus.flick !== 1'b0) begin n_err++; $display("FAIL reset_flick: got %b want 0", bus.flick); end
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_swi();
        logic [1:0] exp_scr [3];
        exp_scr = '{2'd1, 2'd2, 2'd0};
        for (int i = 0; i < 3; i++) begin
            tap(K_SWI);
            n_vec++;
            if (bus.screen !== exp_scr[i]) begin
                n_err++;
                $display("FAIL swi_tap%0d: screen got %0d want %0d", i, bus.screen, exp_scr[i]);
            end
        end
    endtask

    task automatic test_bounce();
        int s;
        tap(K_EDIT);
        n_vec++; if (bus.edit_mode !== 1'b1) begin n_err++; $display("FAIL enter_edit: got %b want 1", bus.edit_mode); end
        clear_log();
        set_key(K_PLUS, 1'b0); step(1);
        set_key(K_PLUS, 1'b1); step(1);
        set_key(K_PLUS, 1'b0); step(1);
        set_key(K_PLUS, 1'b1); step(1);
        set_key(K_PLUS, 1'b0);
        s = cyc;
        step(12);
        set_key(K_PLUS, 1'b1);
        step(10);
        n_vec++; if (n_inc !== 1) begin n_err++; $display("FAIL bounce_count: got %0d want 1", n_inc); end
        n_vec++;
        if (inc_t.size() < 1 || inc_t[0] !== s + 7) begin
            n_err++;
            $display("FAIL bounce_time: got %0d want %0d", (inc_t.size() > 0) ? inc_t[0] - s : -1, 7);
        end
    endtask

    task automatic test_repeat();
        int d;
        int off [9];
        off = '{0, 20, 25, 30, 35, 40, 45, 50, 55};
        clear_log();
        set_key(K_PLUS, 1'b0);
        d = cyc;
        step(60);
        set_key(K_PLUS, 1'b1);
        step(15);
        n_vec++; if (n_inc !== 9) begin n_err++; $display("FAIL repeat_count: got %0d want 9", n_inc); end
        n_vec++; if (n_dec !== 0) begin n_err++; $display("FAIL repeat_no_dec: got %0d want 0", n_dec); end
        for (int i = 0; i < 9; i++) begin
            n_vec++;
            if (i >= inc_t.size()) begin
                n_err++;
                $display("FAIL repeat_time%0d: got none want t0+%0d", i, off[i]);
            end else if (inc_t[i] !== d + 7 + off[i]) begin
                n_err++;
                $display("FAIL repeat_time%0d: got t0+%0d want t0+%0d", i, inc_t[i] - d - 7, off[i]);
            end
        end
    endtask

    task automatic test_edit_fields();
        tap(K_EDIT);
        n_vec++; if (bus.edit_pos !== 3'd2) begin n_err++; $display("FAIL field1_pos: got %0d want 2", bus.edit_pos); end
        tap(K_EDIT);
        n_vec++; if (bus.edit_pos !== 3'd4) begin n_err++; $display("FAIL field2_pos: got %0d want 4", bus.edit_pos); end
        tap(K_SWI);
        n_vec++; if (bus.screen !== 2'd0) begin n_err++; $display("FAIL swi_in_edit: screen got %0d want 0", bus.screen); end
        tap(K_EDIT);
        n_vec++; if (bus.edit_mode !== 1'b0) begin n_err++; $display("FAIL field_exit_mode: got %b want 0", bus.edit_mode); end
        n_vec++; if (bus.edit_pos !== 3'd0) begin n_err++; $display("FAIL field_exit_pos: got %0d want 0", bus.edit_pos); end
        tap(K_SWI);
        tap(K_SWI);
        n_vec++; if (bus.screen !== 2'd2) begin n_err++; $display("FAIL tz_screen: got %0d want 2", bus.screen); end
        tap(K_EDIT);
        n_vec++; if (bus.edit_mode !== 1'b0) begin n_err++; $display("FAIL tz_edit_ignored: got %b want 0", bus.edit_mode); end
        tap(K_SWI);
        n_vec++; if (bus.screen !== 2'd0) begin n_err++; $display("FAIL tz_wrap: got %0d want 0", bus.screen); end
    endtask

    task automatic test_timeout();
        set_key(K_EDIT, 1'b0);
        step(7);
        n_vec++; if (bus.edit_mode !== 1'b1) begin n_err++; $display("FAIL to_enter: got %b want 1", bus.edit_mode); end
        step(1);
        set_key(K_EDIT, 1'b1);
        step(7);
        n_vec++; if (bus.flick !== 1'b1) begin n_err++; $display("FAIL flick_first: got %b want 1", bus.flick); end
        step(91);
        n_vec++; if (bus.edit_mode !== 1'b1) begin n_err++; $display("FAIL to_early: got %b want 1", bus.edit_mode); end
        step(1);
        n_vec++; if (bus.edit_mode !== 1'b0) begin n_err++; $display("FAIL to_expire: got %b want 0", bus.edit_mode); end
        n_vec++; if (bus.edit_pos !== 3'd0) begin n_err++; $display("FAIL to_pos: got %0d want 0", bus.edit_pos); end

        clear_log();
        set_key(K_EDIT, 1'b0);
        step(7);
        step(1);
        set_key(K_EDIT, 1'b1);
        step(91);
        set_key(K_MINUS, 1'b0);
        step(7);
        n_vec++; if (bus.dec_pulse !== 1'b1) begin n_err++; $display("FAIL to_minus_dec: got %b want 1", bus.dec_pulse); end
        step(1);
        set_key(K_MINUS, 1'b1);
        n_vec++; if (bus.edit_mode !== 1'b1) begin n_err++; $display("FAIL to_restart: got %b want 1", bus.edit_mode); end
        step(5);
        n_vec++; if (bus.flick !== 1'b0) begin n_err++; $display("FAIL flick_rephase: got %b want 0", bus.flick); end
        step(2);
        n_vec++; if (bus.flick !== 1'b1) begin n_err++; $display("FAIL flick_after_step: got %b want 1", bus.flick); end
        step(91);
        n_vec++; if (bus.edit_mode !== 1'b1) begin n_err++; $display("FAIL to_window_early: got %b want 1", bus.edit_mode); end
        step(1);
        n_vec++; if (bus.edit_mode !== 1'b0) begin n_err++; $display("FAIL to_window_expire: got %b want 0", bus.edit_mode); end
        n_vec++; if (n_dec !== 1) begin n_err++; $display("FAIL to_dec_count: got %0d want 1", n_dec); end
    endtask

    task automatic test_both();
        int r;
        tap(K_EDIT);
        clear_log();
        set_key(K_PLUS, 1'b0);
        set_key(K_MINUS, 1'b0);
        step(50);
        r = cyc;
        n_vec++; if (n_inc !== 0) begin n_err++; $display("FAIL both_inc: got %0d want 0", n_inc); end
        n_vec++; if (n_dec !== 0) begin n_err++; $display("FAIL both_dec: got %0d want 0", n_dec); end
        set_key(K_MINUS, 1'b1);
        step(27);
        set_key(K_PLUS, 1'b1);
        step(15);
        n_vec++; if (n_inc !== 2) begin n_err++; $display("FAIL resume_count: got %0d want 2", n_inc); end
        n_vec++;
        if (inc_t.size() < 1 || inc_t[0] !== r + 26) begin
            n_err++;
            $display("FAIL resume_first: got r+%0d want r+26", (inc_t.size() > 0) ? inc_t[0] - r : -1);
        end
        n_vec++;
        if (inc_t.size() < 2 || inc_t[1] !== r + 31) begin
            n_err++;
            $display("FAIL resume_second: got r+%0d want r+31", (inc_t.size() > 1) ? inc_t[1] - r : -1);
        end
        n_vec++; if (n_dec !== 0) begin n_err++; $display("FAIL resume_dec: got %0d want 0", n_dec); end
    endtask

    task automatic test_reset_mid();
        clear_log();
        set_key(K_PLUS, 1'b0);
        step(31);
        n_vec++; if (n_inc !== 2) begin n_err++; $display("FAIL mid_pre_count: got %0d want 2", n_inc); end
        reset = 1'b1;
        step(1);
        n_vec++; if (bus.inc_pulse !== 1'b0) begin n_err++; $display("FAIL mid_inc: got %b want 0", bus.inc_pulse); end
        n_vec++; if (bus.edit_mode !== 1'b0) begin n_err++; $display("FAIL mid_mode: got %b want 0", bus.edit_mode); end
        n_vec++; if (bus.edit_pos !== 3'd0) begin n_err++; $display("FAIL mid_pos: got %0d want 0", bus.edit_pos); end
        n_vec++; if (bus.flick !== 1'b0) begin n_err++; $display("FAIL mid_flick: got %b want 0", bus.flick); end
        set_key(K_PLUS, 1'b1);
        step(1);
        reset = 1'b0;
        clear_log();
        step(30);
        n_vec++; if (n_inc !== 0) begin n_err++; $display("FAIL mid_post_count: got %0d want 0", n_inc); end
        n_vec++; if (bus.edit_mode !== 1'b0) begin n_err++; $display("FAIL mid_post_mode: got %b want 0", bus.edit_mode); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        clear_log();
        bus.key_edit  = 1'b1;
        bus.key_plus  = 1'b1;
        bus.key_minus = 1'b1;
        bus.key_swi   = 1'b1;
        reset = 1'b1;
        test_reset();
        test_swi();
        test_bounce();
        test_repeat();
        test_edit_fields();
        test_timeout();
        test_both();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
